// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//   Registered back end for the 4-bit ripple adder. Each {carry,sum} result
//   (0..31) is taken over a valid/ready handshake. BEATS results are summed
//   into an ACC_W-bit frame total, which is then offered downstream over a
//   second valid/ready handshake.
//
//   Optional build macro: ADDER_ACC_SATURATE_EN
//     defined   : once a frame overflows, acc_out pins at all ones for the
//                 rest of that frame
//     undefined : acc_out wraps modulo 2**ACC_W
//   The overflow flag is sticky within a frame in both builds.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for the first beat of a frame; previous total still shown
//   ACCUM | frame in progress, 1..BEATS-1 beats accepted
//   DONE  | frame complete, held on acc_out/overflow until the consumer takes it
module adder_sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int BEATS = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // A one-beat frame is complete on its very first accept.
  localparam bit SINGLE_BEAT = (BEATS == 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W:0]   beat_ext;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat_acc;
  logic             out_take;
  logic             frame_last;
  logic             ovf_now;

  // Beat value zero-extended by one bit so the add exposes its carry-out.
  always_comb begin
    beat_ext = {{(ACC_W-4){1'b0}}, carry, sum};
    acc_sum  = {1'b0, acc_q} + beat_ext;
    cnt_inc  = cnt_q + CNT_W'(1);
    frame_last = (cnt_inc == CNT_W'(BEATS));
    ovf_now  = acc_sum[ACC_W];
  end

  // Handshake strobes; both ready and valid depend only on registered state.
  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
    beat_acc  = in_valid & in_ready;
    out_take  = out_valid & out_ready;
  end

  // Next-state and datapath update for the frame sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          // First beat starts a fresh frame: no residue from the previous one.
          acc_d   = beat_ext[ACC_W-1:0];
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = SINGLE_BEAT ? S_DONE : S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (beat_acc) begin
          ovf_d = ovf_q | ovf_now;
`ifdef ADDER_ACC_SATURATE_EN
          // Once saturated, stay pinned even if later beats are zero.
          if (ovf_q || ovf_now) begin
            acc_d = '1;
          end else begin
            acc_d = acc_sum[ACC_W-1:0];
          end
`else
          acc_d = acc_sum[ACC_W-1:0];
`endif
          cnt_d = cnt_inc;
          if (frame_last) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Total and flag are left visible after the take; only the count clears.
        if (out_take) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered values drive the outputs directly.
  always_comb begin
    acc_out  = acc_q;
    overflow = ovf_q;
    beat_cnt = cnt_q;
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: directed frame checks on three
// parameterisations plus a randomized scoreboard run on the 6-bit instance.
module tb_adder_sum_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: ACC_W=8, BEATS=4
  logic       a_in_valid, a_in_ready, a_carry, a_out_valid, a_out_ready, a_overflow;
  logic [3:0] a_sum;
  logic [7:0] a_acc_out, a_beat_cnt;
  // Instance B: ACC_W=6, BEATS=4
  logic       b_in_valid, b_in_ready, b_carry, b_out_valid, b_out_ready, b_overflow;
  logic [3:0] b_sum;
  logic [5:0] b_acc_out;
  logic [7:0] b_beat_cnt;
  // Instance C: ACC_W=8, BEATS=1
  logic       c_in_valid, c_in_ready, c_carry, c_out_valid, c_out_ready, c_overflow;
  logic [3:0] c_sum;
  logic [7:0] c_acc_out, c_beat_cnt;

  adder_sum_accumulator #(.ACC_W(8), .BEATS(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sum(a_sum), .carry(a_carry), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .acc_out(a_acc_out), .overflow(a_overflow), .beat_cnt(a_beat_cnt));

  adder_sum_accumulator #(.ACC_W(6), .BEATS(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum(b_sum), .carry(b_carry), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .acc_out(b_acc_out), .overflow(b_overflow), .beat_cnt(b_beat_cnt));

  adder_sum_accumulator #(.ACC_W(8), .BEATS(1), .CNT_W(8)) u_dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sum(c_sum), .carry(c_carry), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .acc_out(c_acc_out), .overflow(c_overflow), .beat_cnt(c_beat_cnt));

  int n_vec = 0;
  int n_err = 0;
  bit sb_en = 1'b0;

  typedef struct {
    int acc;
    int ovf;
  } exp_t;
  exp_t exp_q[$];
  int m_total = 0;
  int m_cnt = 0;
  int frames_pushed = 0;
  int frames_taken = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: frame total of a w-bit accumulator given the true integer sum.
  function automatic int ref_acc(input int total, input int w);
    int lim;
    lim = 1 << w;
    if (total < lim) return total;
`ifdef ADDER_ACC_SATURATE_EN
    return lim - 1;
`else
    return total % lim;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input int v);
    logic [4:0] vb;
    vb = v[4:0];
    a_in_valid = 1'b1;
    a_sum = vb[3:0];
    a_carry = vb[4];
    tick();
  endtask

  // Scoreboard producer: every accepted beat feeds the integer model.
  always @(negedge clk) begin
    if (sb_en && !reset && b_in_valid && b_in_ready) begin
      chk("b_cnt_at_accept", b_beat_cnt, m_cnt);
      m_total = m_total + int'({b_carry, b_sum});
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back('{acc: ref_acc(m_total, 6), ovf: (m_total > 63) ? 1 : 0});
        frames_pushed++;
        m_total = 0;
        m_cnt = 0;
      end
    end
  end

  // Scoreboard consumer: compare each presented frame as it is taken.
  always @(negedge clk) begin
    exp_t e;
    if (sb_en && !reset && b_out_valid) begin
      chk("b_in_ready_in_done", b_in_ready, 0);
      if (b_out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL b_unexpected_frame actual=acc %0d required=no frame", b_acc_out);
        end else begin
          e = exp_q.pop_front();
          chk("b_frame_acc", b_acc_out, e.acc);
          chk("b_frame_ovf", b_overflow, e.ovf);
          chk("b_frame_cnt", b_beat_cnt, 4);
          frames_taken++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit b_acc_now;
    int pat[7];
    int waited;
    logic [4:0] rv;

    reset = 1'b1;
    a_in_valid = 0; a_sum = 0; a_carry = 0; a_out_ready = 0;
    b_in_valid = 0; b_sum = 0; b_carry = 0; b_out_ready = 0;
    c_in_valid = 0; c_sum = 0; c_carry = 0; c_out_ready = 0;
    #12;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_acc", a_acc_out, 0);
    chk("rst_a_ovf", a_overflow, 0);
    chk("rst_a_cnt", a_beat_cnt, 0);
    chk("rst_c_out_valid", c_out_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: 19,5,31,0 back-to-back.
    a_beat(19);
    a_beat(5);
    a_beat(31);
    chk("t1_no_valid_early", a_out_valid, 0);
    chk("t1_cnt3", a_beat_cnt, 3);
    a_beat(0);
    chk("t1_out_valid", a_out_valid, 1);
    chk("t1_acc", a_acc_out, 8'h37);
    chk("t1_ovf", a_overflow, 0);
    chk("t1_cnt", a_beat_cnt, 4);
    chk("t1_in_ready", a_in_ready, 0);

    // Test 2: backpressure in DONE while upstream keeps offering data.
    a_in_valid = 1'b1; a_sum = 4'hF; a_carry = 1'b1; a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", a_out_valid, 1);
      chk("t2_hold_in_ready", a_in_ready, 0);
      chk("t2_hold_acc", a_acc_out, 8'h37);
      chk("t2_hold_cnt", a_beat_cnt, 4);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("t2_idle_out_valid", a_out_valid, 0);
    chk("t2_idle_in_ready", a_in_ready, 1);
    chk("t2_idle_cnt", a_beat_cnt, 0);
    chk("t2_idle_acc_kept", a_acc_out, 8'h37);

    // Test 4: gapped in_valid, v=1 each.
    pat = '{1, 0, 0, 1, 0, 1, 1};
    a_sum = 4'd1; a_carry = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (pat[k] == 0) begin
        a_sum = 4'(k + 3);
      end else begin
        a_sum = 4'd1;
      end
      a_in_valid = pat[k][0];
      tick();
      chk("t4_out_valid_step", a_out_valid, (k == 6) ? 1 : 0);
    end
    a_in_valid = 1'b0;
    chk("t4_acc", a_acc_out, 4);
    chk("t4_cnt", a_beat_cnt, 4);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Test 5: reset mid-frame, then a clean frame of 2s.
    a_beat(7);
    a_beat(7);
    a_in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_acc", a_acc_out, 0);
    chk("t5_rst_cnt", a_beat_cnt, 0);
    chk("t5_rst_in_ready", a_in_ready, 1);
    chk("t5_rst_out_valid", a_out_valid, 0);
    chk("t5_rst_ovf", a_overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) a_beat(2);
    a_in_valid = 1'b0;
    chk("t5_out_valid", a_out_valid, 1);
    chk("t5_acc", a_acc_out, 8);
    chk("t5_ovf", a_overflow, 0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Test 6: single-beat frames.
    c_in_valid = 1'b1; c_sum = 4'd1; c_carry = 1'b1;
    tick();
    c_in_valid = 1'b0;
    chk("t6_out_valid", c_out_valid, 1);
    chk("t6_acc", c_acc_out, 17);
    chk("t6_cnt", c_beat_cnt, 1);
    chk("t6_in_ready", c_in_ready, 0);
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
    chk("t6_back_idle", c_out_valid, 0);

    // Test 3: four beats of 31 into a 6-bit accumulator.
    b_in_valid = 1'b1; b_sum = 4'hF; b_carry = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    b_in_valid = 1'b0;
    chk("t3_out_valid", b_out_valid, 1);
    chk("t3_acc", b_acc_out, ref_acc(124, 6));
    chk("t3_ovf", b_overflow, 1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    // Randomized run on instance B against the scoreboard.
    sb_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      b_acc_now = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
      if (!(b_in_valid && !b_acc_now)) begin
        rv = 5'($urandom);
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_sum = rv[3:0];
        b_carry = rv[4];
      end
      b_out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    b_acc_now = b_in_valid && b_in_ready;
    @(posedge clk);
    #1;
    if (b_in_valid && !b_acc_now) begin
      // Let a still-pending beat land before dropping valid.
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    tick();
    chk("b_drain_empty", exp_q.size(), 0);
    chk("b_frames_taken", frames_taken, frames_pushed);
    chk("b_partial_cnt", b_beat_cnt, m_cnt);
    sb_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
